// File: rtl/timebase_pkg.sv
// Shared constants and helpers for the multi-rate timebase: counter width,
// system clock rate and the standard half-periods at 100 MHz.
package timebase_pkg;

    localparam int TB_CNT_W = 32;
    localparam int SYS_CLK_HZ = 100_000_000;

    localparam logic [TB_CNT_W-1:0] HALF_500US = 32'd25_000;
    localparam logic [TB_CNT_W-1:0] HALF_1MS   = 32'd50_000;
    localparam logic [TB_CNT_W-1:0] HALF_2MS   = 32'd100_000;
    localparam logic [TB_CNT_W-1:0] HALF_1S    = 32'd50_000_000;

    // Channel-select width; at least one bit even for a single channel.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timebase_channel.sv
// One timebase channel: programmable half-period register, counter, square
// wave toggle and a one-cycle tick on each rising edge of the wave.
module timebase_channel
    import timebase_pkg::*;
#(
    parameter int CNT_W = TB_CNT_W,
    parameter logic [CNT_W-1:0] RESET_HALF = HALF_1MS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    input  logic             clr,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term;

    // A zero half-period behaves like one: toggle every cycle.
    assign term = (hp == '0) ? '0 : hp - CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hp      <= RESET_HALF;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (wr)
                hp <= wr_half;
            // Clear beats a write, and a write beats a terminal count.
            if (clr) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (wr) begin
                cnt <= '0;
            end else if (cnt_en) begin
                if (cnt == term) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= ~clk_out;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_rate_timebase.sv
// NUM_CH independent programmable square-wave dividers with per-channel ticks.
// Define TIMEBASE_SYNC_CLEAR_EN to add the sync_clr phase-align input.
module multi_rate_timebase
    import timebase_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = TB_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_HALF = {HALF_1MS, HALF_1S, HALF_2MS, HALF_500US}
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef TIMEBASE_SYNC_CLEAR_EN
    input  logic                     sync_clr,
`endif
    input  logic                     en,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     cfg_we,
    input  logic [ch_w(NUM_CH)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]         cfg_half,
    output logic [NUM_CH-1:0]        clk_out,
    output logic [NUM_CH-1:0]        tick
);

    localparam int CH_W = ch_w(NUM_CH);

    logic clr;

`ifdef TIMEBASE_SYNC_CLEAR_EN
    assign clr = sync_clr;
`else
    assign clr = 1'b0;
`endif

    // Selects at or beyond NUM_CH match no channel, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == CH_W'(i));

        timebase_channel #(
            .CNT_W      (CNT_W),
            .RESET_HALF (DEFAULT_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .cnt_en  (en & ch_en[i]),
            .wr      (wr),
            .wr_half (cfg_half),
            .clr     (clr),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
